// File: rtl/pecell_chan_buf.sv
// Multi-channel stream buffer: one FIFO per channel, command-driven WRITE/READ/FLUSH
// sequencing, with an APB register window for channel enables, flags and status.
module pecell_chan_buf #(
    parameter int WID_BUS = 32,
    parameter int DEPTH   = 16,
    parameter int NUM_CH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               psel,
    input  logic [3:0]         paddr,
    input  logic               pwrite,
    input  logic [7:0]         pwdata,
    input  logic               penable,
    output logic [7:0]         prdata,
    output logic               pready,
    input  logic [WID_BUS-1:0] wdata,
    input  logic               wdata_valid,
    output logic               wdata_busy,
    input  logic               wdata_last,
    output logic [WID_BUS-1:0] rdata,
    output logic               rdata_valid,
    input  logic               rdata_busy,
    output logic               rdata_last,
    input  logic               cs_n,
    input  logic               cvalid,
    input  logic [1:0]         work_mode,
    input  logic [4:0]         waddr,
    output logic               pe_busy
);
    localparam int CW = $clog2(NUM_CH);
    localparam int AW = $clog2(DEPTH);

    // state   | meaning
    // S_IDLE  | waiting for a command
    // S_WRITE | accepting beats into the selected channel until last
    // S_READ  | presenting head entries of the selected channel until last
    // S_FLUSH | clearing the selected channel, back to idle next edge
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    state_e            r_state, w_state_nxt;
    logic [CW-1:0]     r_ch, w_cmd_ch;
    logic              r_err;
    logic [NUM_CH-1:0] r_ch_en, w_empty, w_full;
    logic [AW-1:0]     r_wptr [NUM_CH];
    logic [AW-1:0]     r_rptr [NUM_CH];
    logic [AW:0]       r_cnt  [NUM_CH];
    logic [WID_BUS:0]  r_mem  [NUM_CH][DEPTH];
    logic              w_cmd, w_accept, w_err_set, w_wr, w_rd, w_apb_wr;
    logic [WID_BUS:0]  w_head;
    logic [7:0]        w_rd_word;
    logic              w_unused_ok;

    assign w_cmd       = !cs_n && cvalid;
    assign w_cmd_ch    = waddr[CW-1:0];
    assign w_apb_wr    = psel && penable && pwrite;
    assign w_unused_ok = &{1'b0, waddr, pwdata, w_accept};

    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_empty[i] = (r_cnt[i] == '0);
            w_full[i]  = (r_cnt[i] == (AW+1)'(DEPTH));
        end
    end

    // Outputs are forced to their idle values while rst is asserted.
    assign pe_busy     = !rst && (r_state != S_IDLE);
    assign wdata_busy  = rst || (r_state != S_WRITE) || w_full[r_ch];
    assign w_wr        = wdata_valid && !wdata_busy;
    assign w_head      = r_mem[r_ch][r_rptr[r_ch]];
    assign rdata_valid = !rst && (r_state == S_READ) && !w_empty[r_ch];
    assign rdata       = rdata_valid ? w_head[WID_BUS-1:0] : '0;
    assign rdata_last  = rdata_valid && w_head[WID_BUS];
    assign w_rd        = rdata_valid && !rdata_busy;
    assign pready      = 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd) begin
                    if (work_mode == 2'd3 || !r_ch_en[w_cmd_ch]) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        case (work_mode)
                            2'd0:    w_state_nxt = S_WRITE;
                            2'd1:    w_state_nxt = S_READ;
                            default: w_state_nxt = S_FLUSH;
                        endcase
                    end
                end
            end
            S_WRITE: begin
                w_err_set = w_cmd;
                if (w_wr && wdata_last) w_state_nxt = S_IDLE;
            end
            S_READ: begin
                w_err_set = w_cmd;
                if (w_rd && w_head[WID_BUS]) w_state_nxt = S_IDLE;
            end
            default: begin
                w_err_set   = w_cmd;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_ch][r_wptr[r_ch]] <= {wdata_last, wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_err   <= 1'b0;
            r_ch_en <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_ch <= w_cmd_ch;
            // A new error outranks a simultaneous write-1-to-clear.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_apb_wr && paddr == 4'h3 && pwdata[0]) begin
                r_err <= 1'b0;
            end
            if (w_apb_wr && paddr == 4'h0) r_ch_en <= pwdata[NUM_CH-1:0];
            if (w_wr) begin
                r_wptr[r_ch] <= r_wptr[r_ch] + 1'b1;
                r_cnt[r_ch]  <= r_cnt[r_ch] + 1'b1;
            end
            if (w_rd) begin
                r_rptr[r_ch] <= r_rptr[r_ch] + 1'b1;
                r_cnt[r_ch]  <= r_cnt[r_ch] - 1'b1;
            end
            if (r_state == S_FLUSH) begin
                r_wptr[r_ch] <= '0;
                r_rptr[r_ch] <= '0;
                r_cnt[r_ch]  <= '0;
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        case (paddr)
            4'h0:    w_rd_word[NUM_CH-1:0] = r_ch_en;
            4'h1:    w_rd_word[NUM_CH-1:0] = w_empty;
            4'h2:    w_rd_word[NUM_CH-1:0] = w_full;
            4'h3:    w_rd_word[2:0]        = {r_state, r_err};
            default: w_rd_word             = '0;
        endcase
    end

    assign prdata = (psel && !pwrite && !rst) ? w_rd_word : '0;

endmodule

// File: tb/tb_pecell_chan_buf.sv
// Directed bench for pecell_chan_buf: read beats are checked by a queue-based
// monitor, register and handshake values by direct compares.
module tb_pecell_chan_buf;
    localparam int WID_BUS = 32;
    localparam int DEPTH   = 16;
    localparam int NUM_CH  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               psel = 1'b0, pwrite = 1'b0, penable = 1'b0;
    logic [3:0]         paddr = '0;
    logic [7:0]         pwdata = '0;
    logic [7:0]         prdata;
    logic               pready;
    logic [WID_BUS-1:0] wdata = '0;
    logic               wdata_valid = 1'b0, wdata_last = 1'b0;
    logic               wdata_busy;
    logic [WID_BUS-1:0] rdata;
    logic               rdata_valid, rdata_last;
    logic               rdata_busy = 1'b0;
    logic               cs_n = 1'b1, cvalid = 1'b0;
    logic [1:0]         work_mode = '0;
    logic [4:0]         waddr = '0;
    logic               pe_busy;

    int n_vec = 0;
    int n_err = 0;
    logic [WID_BUS:0] exp_q [$];
    logic [WID_BUS:0] m_exp;

    pecell_chan_buf #(.WID_BUS(WID_BUS), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst),
        .psel(psel), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .penable(penable),
        .prdata(prdata), .pready(pready),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_busy(wdata_busy), .wdata_last(wdata_last),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_busy(rdata_busy), .rdata_last(rdata_last),
        .cs_n(cs_n), .cvalid(cvalid), .work_mode(work_mode), .waddr(waddr), .pe_busy(pe_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Read-stream monitor: every transferring beat must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (rdata_valid) begin
                if (!rdata_busy) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rd_unexpected: got 0x%0h, expected no beat", rdata);
                    end else begin
                        m_exp = exp_q.pop_front();
                        check("rd_beat", {rdata_last, rdata}, m_exp);
                    end
                end
            end else begin
                check("rd_idle_zero", {rdata_last, rdata}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string nm, input logic [3:0] a, input logic [7:0] exp);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        #2;
        check(nm, prdata, exp);
        psel = 1'b0;
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [7:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] m, input logic [4:0] ch);
        cs_n = 1'b0; cvalid = 1'b1; work_mode = m; waddr = ch;
        tick();
        cs_n = 1'b1; cvalid = 1'b0;
    endtask

    task automatic wr_beat(input logic [WID_BUS-1:0] d, input logic last, input string nm);
        bit ok = 0;
        wdata_valid = 1'b1; wdata = d; wdata_last = last;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!wdata_busy) begin
                ok = 1;
                break;
            end
        end
        tick();
        wdata_valid = 1'b0; wdata_last = 1'b0;
        check(nm, ok, 1);
    endtask

    task automatic read_drain(input int max_cyc, input string nm);
        bit done = 0;
        for (int k = 0; k < max_cyc; k++) begin
            rdata_busy = (k % 3 == 2);
            @(negedge clk);
            if (!pe_busy) begin
                done = 1;
                break;
            end
            tick();
        end
        rdata_busy = 1'b0;
        tick();
        check(nm, done, 1);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        @(negedge clk);
        check({nm, "_in_pe_busy"}, pe_busy, 0);
        check({nm, "_in_wdata_busy"}, wdata_busy, 1);
        check({nm, "_in_rdata_valid"}, rdata_valid, 0);
        tick();
        rst = 1'b0; wdata_valid = 1'b0; wdata_last = 1'b0; rdata_busy = 1'b0;
        @(negedge clk);
        check({nm, "_out_pe_busy"}, pe_busy, 0);
        tick();
        chk_reg({nm, "_status"}, 4'h3, 8'h00);
        chk_reg({nm, "_empty"}, 4'h1, 8'h0F);
    endtask

    initial begin
        // Reset values.
        @(negedge clk);
        check("rst_pe_busy", pe_busy, 0);
        check("rst_wdata_busy", wdata_busy, 1);
        check("rst_rdata_valid", rdata_valid, 0);
        check("rst_rdata", {rdata_last, rdata}, 0);
        check("rst_pready", pready, 1);
        check("rst_prdata", prdata, 0);
        tick();
        tick();
        rst = 1'b0;
        chk_reg("rst_ch_en", 4'h0, 8'h0F);
        chk_reg("rst_empty", 4'h1, 8'h0F);
        chk_reg("rst_full", 4'h2, 8'h00);
        chk_reg("rst_status", 4'h3, 8'h00);
        chk_reg("unmapped", 4'h7, 8'h00);

        // Three beats on ch1, then read back.
        cmd(2'd0, 5'd1);
        check("t1_busy_write", pe_busy, 1);
        wr_beat(32'hA, 1'b0, "t1_wr");
        wr_beat(32'hB, 1'b0, "t1_wr");
        wr_beat(32'hC, 1'b1, "t1_wr");
        check("t1_idle_after_write", pe_busy, 0);
        chk_reg("t1_empty_after_write", 4'h1, 8'h0D);
        exp_q.push_back({1'b0, 32'hA});
        exp_q.push_back({1'b0, 32'hB});
        exp_q.push_back({1'b1, 32'hC});
        cmd(2'd1, 5'd1);
        read_drain(50, "t1_read_done");
        check("t1_queue_drained", exp_q.size(), 0);
        check("t1_pe_busy", pe_busy, 0);
        chk_reg("t1_empty", 4'h1, 8'h0F);

        // Fill ch0, overflow beat is held off; a READ mid-write is refused.
        cmd(2'd0, 5'd0);
        for (int i = 0; i < DEPTH; i++) wr_beat(32'h100 + i, 1'b0, "t2_wr");
        wdata_valid = 1'b1; wdata = 32'h1FF; wdata_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_busy_full", wdata_busy, 1);
            tick();
        end
        chk_reg("t2_full", 4'h2, 8'h01);
        chk_reg("t2_empty", 4'h1, 8'h0E);
        cmd(2'd1, 5'd0);
        check("t2_still_busy", pe_busy, 1);
        chk_reg("t2_status_err", 4'h3, 8'h03);
        apb_write(4'h3, 8'h01);
        chk_reg("t2_status_clr", 4'h3, 8'h02);
        do_reset("t2_rst");
        chk_reg("t2_full_after_rst", 4'h2, 8'h00);
        chk_reg("t2_ch_en_after_rst", 4'h0, 8'h0F);

        // READ on empty ch2 waits; reset releases it.
        cmd(2'd1, 5'd2);
        for (int i = 0; i < 6; i++) begin
            rdata_busy = i[0];
            @(negedge clk);
            check("t3_rvalid", rdata_valid, 0);
            check("t3_pe_busy", pe_busy, 1);
            tick();
        end
        do_reset("t3_rst");

        // Disabled channel and reserved mode both flag ERR; set beats clear.
        apb_write(4'h0, 8'h0E);
        chk_reg("t4_ch_en", 4'h0, 8'h0E);
        cmd(2'd0, 5'd0);
        check("t4_ignored", pe_busy, 0);
        chk_reg("t4_err", 4'h3, 8'h01);
        apb_write(4'h3, 8'h01);
        chk_reg("t4_err_clr", 4'h3, 8'h00);
        cmd(2'd3, 5'd1);
        check("t4_rsv_ignored", pe_busy, 0);
        chk_reg("t4_rsv_err", 4'h3, 8'h01);
        apb_write(4'h3, 8'h01);
        chk_reg("t4_rsv_clr", 4'h3, 8'h00);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 4'h3; pwdata = 8'h01;
        tick();
        penable = 1'b1; cs_n = 1'b0; cvalid = 1'b1; work_mode = 2'd3; waddr = 5'd0;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; cs_n = 1'b1; cvalid = 1'b0;
        chk_reg("t4_set_wins", 4'h3, 8'h01);
        apb_write(4'h3, 8'h01);
        apb_write(4'h0, 8'h0F);

        // Five beats on ch3 (disabling ch3 mid-write must not abort), then FLUSH.
        cmd(2'd0, 5'd3);
        wr_beat(32'h31, 1'b0, "t5_wr");
        wr_beat(32'h32, 1'b0, "t5_wr");
        apb_write(4'h0, 8'h07);
        check("t5_no_abort", pe_busy, 1);
        wr_beat(32'h33, 1'b0, "t5_wr");
        wr_beat(32'h34, 1'b0, "t5_wr");
        wr_beat(32'h35, 1'b1, "t5_wr");
        check("t5_write_done", pe_busy, 0);
        chk_reg("t5_empty_before", 4'h1, 8'h07);
        apb_write(4'h0, 8'h0F);
        cmd(2'd2, 5'd3);
        check("t5_flush_busy", pe_busy, 1);
        chk_reg("t5_flush_state", 4'h3, 8'h06);
        tick();
        chk_reg("t5_empty_after", 4'h1, 8'h0F);
        check("t5_flush_idle", pe_busy, 0);
        cmd(2'd1, 5'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_read_wait", rdata_valid, 0);
            check("t5_read_busy", pe_busy, 1);
            tick();
        end
        do_reset("t5_rst");

        // Pointer wrap on ch2: two rounds of DEPTH-1 beats.
        for (int p = 0; p < 2; p++) begin
            cmd(2'd0, 5'd2);
            for (int i = 0; i < DEPTH - 1; i++) begin
                wdata = 32'hC000_0000 + p * 256 + i;
                wr_beat(wdata, (i == DEPTH - 2), "t6_wr");
                exp_q.push_back({(i == DEPTH - 2) ? 1'b1 : 1'b0, 32'hC000_0000 + p * 256 + i});
            end
            check("t6_write_done", pe_busy, 0);
            cmd(2'd1, 5'd2);
            read_drain(100, "t6_read_done");
            check("t6_queue_drained", exp_q.size(), 0);
        end
        chk_reg("t6_empty", 4'h1, 8'h0F);
        chk_reg("t6_full", 4'h2, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
